// File: rtl/square_fx.sv
`default_nettype none
// ============================================================================
// Module   : square_fx
// Purpose  : Sequential fixed-point squarer. Squares an unsigned 8.4 operand
//            with a 12-iteration shift-add multiplier and returns the square
//            rounded to the nearest integer as an unsigned 16-bit value.
// Ports    : CLK       in   1   rising-edge clock
//            RST       in   1   synchronous active-high reset
//            IN_VALID  in   1   one-cycle pulse, IN valid this cycle
//            IN        in  12   operand, unsigned 8.4 (IN[11:4] int, IN[3:0] frac)
//            OUT_VALID out  1   one-cycle pulse, OUT holds a new result
//            OUT       out 16   round(IN^2), unsigned integer
//            BUSY      out  1   operation in flight, IN_VALID ignored
// Revision : 1.0 - initial release
// ============================================================================
module square_fx (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [11:0] IN,
  output logic        OUT_VALID,
  output logic [15:0] OUT,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_ITER = 4'd11;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [11:0] r_op;
  // Square of an 8.4 value is 16.8: acc[23:8] integer part, acc[7] half bit.
  logic [23:0] r_acc;

  // Partial product for the current iteration: operand weighted by bit cnt.
  logic [23:0] w_partial;
  assign w_partial = {12'b0, r_op} << r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= 12'd0;
      r_acc     <= 24'd0;
      OUT       <= 16'd0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_op    <= IN;
            r_acc   <= 24'd0;
            r_cnt   <= 4'd0;
            BUSY    <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_op[r_cnt]) begin
            r_acc <= r_acc + w_partial;
          end
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Max acc is 0xFFE001, so adding the half bit never overflows and
          // exact ties (acc[7:0] == 0x80) cannot occur.
          OUT       <= r_acc[23:8] + {15'd0, r_acc[7]};
          OUT_VALID <= 1'b1;
          BUSY      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_square_fx.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_fx
// Purpose  : Self-checking bench for square_fx. Expected results are queued
//            when an operand is accepted and compared (value and latency)
//            when OUT_VALID pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_fx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic [11:0] IN;
  logic        OUT_VALID;
  logic [15:0] OUT;
  logic        BUSY;

  square_fx dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN        (IN),
    .OUT_VALID (OUT_VALID),
    .OUT       (OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] exp;
    int          acc_cyc;
  } sb_t;

  typedef struct {
    logic [11:0] in;
    logic [15:0] exp;
  } vec_t;

  sb_t sb[$];
  int  cyc     = 0;
  int  n_valid = 0;
  int  asserts = 0;
  int  fails   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] model(input logic [11:0] v);
    int unsigned p;
    p = (int'(v) * int'(v) + 128) >> 8;
    return p[15:0];
  endfunction

  // Output monitor: every OUT_VALID pulse must match the oldest queued result.
  always @(negedge CLK) begin
    if (OUT_VALID) begin
      sb_t e;
      n_valid++;
      if (sb.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_valid: got OUT_VALID=1 OUT=%0d, expected no pulse (cycle %0d)", OUT, cyc);
      end else begin
        e = sb.pop_front();
        check("out_value", OUT, e.exp);
        check("latency", cyc - e.acc_cyc, 13);
      end
    end
  end

  // Drive a one-cycle IN_VALID pulse; entered and left at #1 after an edge.
  task automatic send(input logic [11:0] v, input bit accept, input logic [15:0] exp);
    sb_t e;
    IN = v;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    if (accept) begin
      e.exp = exp;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      asserts++;
      fails++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    int nv0;
    logic [11:0] r;

    vecs[0]  = '{12'h000, 16'd0};
    vecs[1]  = '{12'h010, 16'd1};
    vecs[2]  = '{12'hFFF, 16'd65504};
    vecs[3]  = '{12'h0B5, 16'd128};
    vecs[4]  = '{12'h017, 16'd2};
    vecs[5]  = '{12'h01C, 16'd3};
    vecs[6]  = '{12'h020, 16'd4};
    vecs[7]  = '{12'h030, 16'd9};
    vecs[8]  = '{12'h001, 16'd0};
    vecs[9]  = '{12'h008, 16'd0};
    vecs[10] = '{12'h00C, 16'd1};

    // Reset with an IN_VALID pulse that must not be accepted.
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN = 12'h000;
    @(posedge CLK);
    #1;
    IN = 12'h010;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_out", OUT, 0);
    check("reset_out_valid", OUT_VALID, 0);
    check("reset_busy", BUSY, 0);
    RST = 1'b0;
    IN_VALID = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("reset_no_valid", n_valid, 0);
    check("reset_busy_after", BUSY, 0);

    // Table-driven corner and rounding operands.
    foreach (vecs[i]) begin
      send(vecs[i].in, 1'b1, vecs[i].exp);
      check("busy_after_accept", BUSY, 1);
      wait_done();
      check("busy_idle", BUSY, 0);
    end

    // Busy/ignore: extra pulses at E5 and E13 are dropped, E14 is accepted.
    nv0 = n_valid;
    send(12'h020, 1'b1, 16'd4);                 // E0
    repeat (4) @(posedge CLK);                  // E4
    #1;
    send(12'h030, 1'b0, 16'd0);                 // sampled at E5
    check("busy_mid", BUSY, 1);
    repeat (7) @(posedge CLK);                  // E12
    #1;
    send(12'h030, 1'b0, 16'd0);                 // sampled at E13, ignored
    check("done_out_valid", OUT_VALID, 1);
    check("done_out", OUT, 4);
    send(12'h030, 1'b1, 16'd9);                 // sampled at E14, accepted
    wait_done();
    check("busy_two_pulses", n_valid - nv0, 2);

    // Reset mid-operation discards the result.
    nv0 = n_valid;
    send(12'h0FF, 1'b0, 16'd0);                 // E0
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);                             // E6
    #1;
    RST = 1'b0;
    check("midrst_out", OUT, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_out_valid", OUT_VALID, 0);
    repeat (20) @(posedge CLK);
    #1;
    check("midrst_no_valid", n_valid - nv0, 0);
    send(12'h030, 1'b1, 16'd9);
    wait_done();

    // Random regression.
    nv0 = n_valid;
    for (int i = 0; i < 100; i++) begin
      r = 12'($urandom_range(0, 4095));
      send(r, 1'b1, model(r));
      wait_done();
    end
    check("random_pulse_count", n_valid - nv0, 100);
    check("queue_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
